sm9_accumulator: RTL
====================

Name: sm9_accumulator

Overview:
- Sequential accumulator directly downstream of the 9-bit sign-magnitude adder stage in the TPU datapath.
- Consumes a stream of 9-bit sign-magnitude values: bit 8 is the sign (1 = negative), bits 7:0 are the magnitude.
- Sums one group of values per transaction and emits a single saturated 9-bit sign-magnitude result with an overflow flag.
- Uses valid/ready handshakes on both sides.

Parameters:
- LENGTH, 4: maximum beats per group; legal range 1..255.
- SATURATE, 1: 1 clamps the magnitude to 255 on overflow; 0 wraps the magnitude modulo 256. The overflow flag is set in both modes.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data and in_last are valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  9  sign-magnitude operand.
- in_last  input  1  this beat closes the group early.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_data  output  9  sign-magnitude group sum.
- out_overflow  output  1  magnitude exceeded 255 at least once in this group.
- out_count  output  8  number of beats summed into out_data.
- busy  output  1  high in ACCUM or DONE.

Behaviour:
- Reset: asynchronous on rst_n low.
  - State goes to IDLE; accumulator, count and overflow register go to 0.
  - Outputs during and after reset: out_valid=0, out_data=9'd0, out_overflow=0, out_count=0, busy=0, in_ready=1.
  - Reset mid-group or mid-output discards all partial state; no result is emitted.
- Handshake:
  - An input beat transfers when in_valid && in_ready at a rising edge.
  - The output transfers when out_valid && out_ready.
  - in_ready=1 in IDLE and ACCUM, 0 in DONE.
  - While out_valid=1 and out_ready=0, out_data, out_overflow and out_count hold stable.
- Normalisation: -0 (9'b100000000) is treated as +0 on input. The accumulator and out_data never hold -0.
- Addition, acc (sign sa, magnitude ma) plus input (sign sb, magnitude mb):
  - sa==sb: m = ma+mb, computed at 9 bits.
    - If m>255, set the overflow register.
    - SATURATE=1: magnitude becomes 255.
    - SATURATE=0: magnitude becomes m[7:0].
    - The result sign is sa.
  - sa!=sb: the magnitude is |ma-mb| and the sign is the sign of the larger operand. Equal magnitudes give +0. No overflow is possible.
  - After saturation, later beats operate on the clamped value. The overflow flag is sticky until the group is consumed.
- State machine:
  - IDLE:
    - On an accepted beat: acc = normalised in_data, count = 1, overflow register = 0.
    - If in_last==1 or LENGTH==1, go to DONE; otherwise go to ACCUM.
  - ACCUM:
    - On an accepted beat: acc = acc + in_data and count increments.
    - If in_last==1 or count+1==LENGTH, go to DONE.
    - With no beat, state holds; there is no timeout.
  - DONE:
    - out_valid=1, out_data=acc, out_count=count, out_overflow=overflow register.
    - On out_ready, go to IDLE; the registers keep their values until the next group starts.
    - Inputs are not accepted in DONE. Back-to-back groups therefore incur one bubble cycle per group, plus any out_ready stall.
- Latency: out_valid rises on the clock edge that accepts the closing beat, so it is visible in the following cycle.
- Simultaneous events:
  - in_last on the beat that also reaches LENGTH closes the group once.
  - out_ready asserted outside DONE is ignored.
  - in_valid asserted in DONE is not accepted, and the upstream holds the beat.
- out_valid, in_ready and busy are decoded from registered state only, with no combinational path from out_ready or in_valid.

Test Plan:
1. LENGTH=4; feed +3, -2 (9'b100000010), -3 (9'b100000011), +2 with out_ready=1 → running sums +3, +1, -2, +0. Final out_data=9'd0, out_count=4, out_overflow=0, out_valid high for exactly 1 cycle.
2. Feed +3, then +2 with in_last=1 → out_data=9'd5, out_count=2. Then feed -3, then -2 with in_last → out_data=9'b100000101, out_count=2.
3. SATURATE=1: feed +200, +100 (in_last) → out_data=9'd255, out_overflow=1. Repeat with SATURATE=0 → out_data=9'd44, out_overflow=1. Next group +1, +1 (in_last) → out_overflow=0.
4. Feed -0 alone with in_last → out_data=9'd0, not 9'b100000000. Feed +5, -5 (in_last) → out_data=9'd0.
5. Backpressure: close a group with out_ready=0 for 5 cycles while in_valid=1 → in_ready=0 and out_data stable throughout. When out_ready rises, the next beat is accepted one cycle later.
6. Drive rst_n low for one cycle after 2 of 4 beats → all outputs return to reset values immediately. A fresh 4-beat group of +1 each then yields out_data=9'd4, out_count=4.

Source files
------------

// File: rtl/sm9_accumulator_if.sv
// Handshake bundle for sm9_accumulator.
//   in_*  : upstream beat stream (valid/ready, 9-bit sign-magnitude data, early-close flag)
//   out_* : downstream group result (valid/ready, sum, overflow flag, beat count)
//   busy  : block is mid-group or holding a result
// slave  = accumulator view, master = producer/consumer view.
interface sm9_accumulator_if;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_data;
  logic       out_overflow;
  logic [7:0] out_count;
  logic       busy;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_overflow, out_count, busy
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_overflow, out_count, busy
  );
endinterface

// File: rtl/sm9_accumulator.sv
// Sign-magnitude group accumulator.
// Sums a group of 9-bit sign-magnitude beats (bit 8 = sign, 7:0 = magnitude),
// closing on in_last or after LENGTH beats, and presents one saturated (or
// wrapped) result with a sticky overflow flag and the beat count.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : sm9_accumulator_if.slave (in/out handshakes, result, busy)
module sm9_accumulator #(
  parameter int unsigned LENGTH   = 4,
  parameter bit          SATURATE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sm9_accumulator_if.slave      bus
);

  localparam logic [8:0] LEN9 = 9'(LENGTH);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t     state_q;
  logic [8:0] acc_q;
  logic [7:0] cnt_q;
  logic       ovf_q;

  logic [8:0] in_norm;
  logic [9:0] sum;      // {overflow, sign, magnitude}
  logic [8:0] cnt_nxt;  // one bit wider so LENGTH=255 compares cleanly
  logic       accept;

  // Sign-magnitude add. Only like signs can overflow; the result never
  // carries a negative zero (wrap of -128 + -128 would otherwise give -0).
  function automatic logic [9:0] sm_add(input logic [8:0] a, input logic [8:0] b);
    logic [8:0] m;
    logic [7:0] mag;
    logic       sgn;
    logic       ovf;
    m   = 9'd0;
    ovf = 1'b0;
    sgn = a[8];
    mag = 8'd0;
    if (a[8] == b[8]) begin
      m   = {1'b0, a[7:0]} + {1'b0, b[7:0]};
      ovf = m[8];
      mag = (ovf && SATURATE) ? 8'hFF : m[7:0];
    end else if (a[7:0] > b[7:0]) begin
      mag = a[7:0] - b[7:0];
    end else begin
      mag = b[7:0] - a[7:0];
      sgn = b[8];
    end
    if (mag == 8'd0) sgn = 1'b0;
    return {ovf, sgn, mag};
  endfunction

  always_comb begin
    in_norm = (bus.in_data[7:0] == 8'd0) ? 9'd0 : bus.in_data;
    sum     = sm_add(acc_q, in_norm);
    cnt_nxt = {1'b0, cnt_q} + 9'd1;
    accept  = bus.in_valid && (state_q != DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= 9'd0;
      cnt_q   <= 8'd0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          acc_q   <= in_norm;
          cnt_q   <= 8'd1;
          ovf_q   <= 1'b0;
          state_q <= (bus.in_last || LENGTH == 1) ? DONE : ACCUM;
        end
        ACCUM: if (accept) begin
          acc_q <= sum[8:0];
          cnt_q <= cnt_nxt[7:0];
          ovf_q <= ovf_q | sum[9];
          if (bus.in_last || cnt_nxt == LEN9) state_q <= DONE;
        end
        DONE: if (bus.out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // All handshake outputs come straight from registers.
  assign bus.in_ready     = (state_q != DONE);
  assign bus.out_valid    = (state_q == DONE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.out_data     = acc_q;
  assign bus.out_count    = cnt_q;
  assign bus.out_overflow = ovf_q;

endmodule
